// File: rtl/lab2_stim_checker.sv
// lab2_stim_checker
//   Stimulus generator and response checker for the Lab-2 gate-level block.
//   It steps {a,b,c} through all eight combinations and holds each one for
//   HOLD_CYCLES cycles. On the last cycle of each window it compares x/y
//   with the golden equations:
//     x = (a|b) XNOR c
//     y = a & b
//   It records per-vector failures and a saturating mismatch count.
//
// Parameters
//   HOLD_CYCLES : cycles each vector is driven before it is sampled (>= 1)
//   ERR_W       : width of the error counter (saturates at 2^ERR_W-1)
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : run request, accepted only while idle
//   x, y      : responses from the combinational block
//   a, b, c   : registered stimulus to the combinational block
//   busy      : high while vectors are being driven
//   done      : one-cycle pulse when a run completes
//   pass      : last completed run had no mismatches
//   err_count : mismatch count of the current or last run
//   fail_vec  : bit i set when vector i mismatched
module lab2_stim_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             x,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_vec
);

    localparam int unsigned      HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [HOLD_W-1:0]  r_hold;
    logic [2:0]         r_idx;
    logic [2:0]         r_abc;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_clean;
    logic [ERR_W-1:0]   r_err;
    logic [7:0]         r_fail;

    logic               w_x_exp;
    logic               w_y_exp;
    logic               w_mismatch;

    // The golden model uses the stimulus currently driven.
    assign w_x_exp    = ~((r_abc[2] | r_abc[1]) ^ r_abc[0]);
    assign w_y_exp    = r_abc[2] & r_abc[1];
    assign w_mismatch = (x != w_x_exp) || (y != w_y_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_idx   <= '0;
            r_abc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_clean <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_err   <= '0;
                        r_fail  <= '0;
                        r_pass  <= 1'b0;
                        r_clean <= 1'b1;
                        r_idx   <= '0;
                        r_abc   <= '0;
                        r_hold  <= HOLD_INIT;
                        r_busy  <= 1'b1;
                        r_state <= S_DRIVE;
                    end
                end

                S_DRIVE: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        if (w_mismatch) begin
                            r_fail[r_idx] <= 1'b1;
                            r_clean       <= 1'b0;
                            if (r_err != ERR_MAX) begin
                                r_err <= r_err + 1'b1;
                            end
                        end
                        if (r_idx != 3'd7) begin
                            r_idx  <= r_idx + 3'd1;
                            r_abc  <= r_idx + 3'd1;
                            r_hold <= HOLD_INIT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // The outputs are registered here, so done and pass
                    // appear one cycle after the final sample. That final
                    // sample has already been folded into r_clean.
                    r_done  <= 1'b1;
                    r_pass  <= r_clean;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a         = r_abc[2];
    assign b         = r_abc[1];
    assign c         = r_abc[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_lab2_stim_checker.sv
// tb_lab2_stim_checker
//   Directed bench for lab2_stim_checker. It uses three checker instances,
//   each wrapped around a behavioural copy of the Lab-2 block:
//     u0 : defaults; its block is either correct or has y stuck at 0
//     u1 : HOLD_CYCLES=4, ERR_W=3; its block has x inverted
//     u2 : HOLD_CYCLES=1; its block is correct and start is held high
module tb_lab2_stim_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st0, st2;
    logic       ystuck0;

    logic       x0, y0, a0, b0, c0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [7:0] fail0;

    logic       x1, y1, a1, b1, c1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [7:0] fail1;

    logic       x2, y2, a2, b2, c2, busy2, done2, pass2;
    logic [3:0] err2;
    logic [7:0] fail2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural Lab-2 blocks, with faults where required.
    assign x0 = ~((a0 | b0) ^ c0);
    assign y0 = ystuck0 ? 1'b0 : (a0 & b0);
    assign x1 = (a1 | b1) ^ c1;
    assign y1 = a1 & b1;
    assign x2 = ~((a2 | b2) ^ c2);
    assign y2 = a2 & b2;

    lab2_stim_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .x(x0), .y(y0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0)
    );

    lab2_stim_checker #(.HOLD_CYCLES(4), .ERR_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st0), .x(x1), .y(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    lab2_stim_checker #(.HOLD_CYCLES(1), .ERR_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .x(x2), .y(y2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int ndone;
        rst_n   = 1'b0;
        st0     = 1'b0;
        st2     = 1'b0;
        ystuck0 = 1'b0;
        #12;
        check("rst_abc",   {a0, b0, c0}, 0);
        check("rst_busy",  busy0, 0);
        check("rst_done",  done0, 0);
        check("rst_pass",  pass0, 0);
        check("rst_err",   err0, 0);
        check("rst_fail",  fail0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);

        // Run 1: u0 clean, u1 with x inverted and a 3-bit saturating counter.
        st0 = 1'b1;
        step(1);
        st0 = 1'b0;
        check("r1_busy", busy0, 1);
        for (int k = 0; k < 32; k++) begin
            check("r1_abc", {a0, b0, c0}, k >> 2);
            step(1);
        end
        check("r1_done_early", done0, 0);
        check("r1_busy_end",   busy0, 0);
        step(1);
        check("r1_done",  done0, 1);
        check("r1_pass",  pass0, 1);
        check("r1_err",   err0, 0);
        check("r1_fail",  fail0, 8'h00);
        check("u1_done",  done1, 1);
        check("u1_pass",  pass1, 0);
        check("u1_err",   err1, 7);
        check("u1_fail",  fail1, 8'hFF);
        step(1);
        check("r1_done_pulse", done0, 0);
        check("r1_pass_hold",  pass0, 1);

        // Run 2: y stuck at 0, so vectors 6 and 7 fail.
        ystuck0 = 1'b1;
        st0 = 1'b1;
        step(1);
        st0 = 1'b0;
        check("r2_pass_clr", pass0, 0);
        step(32);
        check("r2_done_early", done0, 0);
        step(1);
        check("r2_done", done0, 1);
        check("r2_pass", pass0, 0);
        check("r2_err",  err0, 2);
        check("r2_fail", fail0, 8'hC0);
        ystuck0 = 1'b0;
        step(2);

        // Run 3: start pulses during the run and during DONE are ignored.
        st0 = 1'b1;
        step(1);
        st0 = 1'b0;
        step(9);
        st0 = 1'b1;
        step(1);
        st0 = 1'b0;
        check("r3_abc10", {a0, b0, c0}, 3'b010);
        check("r3_busy",  busy0, 1);
        step(22);
        check("r3_done_early", done0, 0);
        check("r3_busy_end",   busy0, 0);
        st0 = 1'b1;
        step(1);
        st0 = 1'b0;
        check("r3_done", done0, 1);
        check("r3_pass", pass0, 1);
        check("r3_err",  err0, 0);
        check("r3_fail", fail0, 8'h00);
        step(1);
        check("r3_no_restart", busy0, 0);
        check("r3_done_pulse", done0, 0);
        step(2);

        // Run 4: reset asserted mid-run at cycle 15.
        st0 = 1'b1;
        step(1);
        st0 = 1'b0;
        step(15);
        check("r4_abc15", {a0, b0, c0}, 3);
        check("r4_u1_err",  err1, 3);
        check("r4_u1_fail", fail1, 8'h07);
        rst_n = 1'b0;
        #1;
        check("r4_rst_abc",  {a0, b0, c0}, 0);
        check("r4_rst_busy", busy0, 0);
        check("r4_rst_err",  err1, 0);
        check("r4_rst_fail", fail1, 0);
        step(2);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (done0) ndone++;
        end
        check("r4_no_done", ndone, 0);
        st0 = 1'b1;
        step(1);
        st0 = 1'b0;
        check("r4_new_abc",  {a0, b0, c0}, 0);
        check("r4_new_busy", busy0, 1);
        step(32);
        check("r4_done_early", done0, 0);
        step(1);
        check("r4_done", done0, 1);
        check("r4_pass", pass0, 1);
        check("r4_err",  err0, 0);
        check("r4_fail", fail0, 8'h00);
        check("r4_u1_err_end",  err1, 7);
        check("r4_u1_fail_end", fail1, 8'hFF);
        step(2);

        // u2: HOLD_CYCLES=1 with start held high, so the checker re-arms
        // after every run.
        st2 = 1'b1;
        step(1);
        for (int k = 0; k < 8; k++) begin
            check("u2_abc", {a2, b2, c2}, k);
            step(1);
        end
        check("u2_busy_end", busy2, 0);
        check("u2_done8",    done2, 0);
        step(1);
        check("u2_done9", done2, 1);
        check("u2_pass9", pass2, 1);
        step(1);
        check("u2_done10",  done2, 0);
        check("u2_rearm",   busy2, 1);
        check("u2_passclr", pass2, 0);
        check("u2_abc10",   {a2, b2, c2}, 0);
        step(8);
        check("u2_done18", done2, 0);
        step(1);
        check("u2_done19", done2, 1);
        check("u2_pass19", pass2, 1);
        check("u2_err19",  err2, 0);
        check("u2_fail19", fail2, 8'h00);
        st2 = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lab2_stim_checker.md
Name: lab2_stim_checker

Overview:
Exhaustive stimulus generator and response checker for the Lab-2 combinational gate-level block (inputs a, b, c; outputs x, y).
- Drives all 8 input combinations in order and holds each for a settle window.
- Samples x/y on the last cycle of each window and compares them against golden equations.
- Reports pass/fail, an error count and a per-vector fail map.
- Wraps the combinational block on the board/bench as its upstream driver and downstream consumer.

Parameters:
HOLD_CYCLES, 4, cycles each vector is held before sampling; legal range >= 1.
ERR_W, 4, width of the error counter; the counter saturates at 2^ERR_W-1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level-sampled run request; accepted only in IDLE.
x  input  1  DUT output x.
y  input  1  DUT output y.
a  output  1  DUT stimulus, registered.
b  output  1  DUT stimulus, registered.
c  output  1  DUT stimulus, registered.
busy  output  1  high while a run is in progress (DRIVE state).
done  output  1  one-cycle pulse when a run completes.
pass  output  1  high when the last completed run had 0 mismatches; held until the next accepted start.
err_count  output  ERR_W  mismatch count of the current/last run; saturating.
fail_vec  output  8  bit i set when vector i mismatched.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, {a,b,c}=000, busy=0, done=0, pass=0, err_count=0, fail_vec=0, hold counter=0, idx=0. Reset mid-run abandons the run with no done pulse.
- Golden model:
  - x_exp = (a|b) XNOR c.
  - y_exp = a&b.
  - These use the registered a/b/c currently driven.
- Vector order: idx 0..7 with {a,b,c}=idx[2:0] (a is the MSB); no wrap within a run.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - done=0, busy=0.
  - start=1 at a rising edge causes: err_count<=0, fail_vec<=0, pass<=0, idx<=0, {a,b,c}<=000, hold<=HOLD_CYCLES-1, then go to DRIVE.
- DRIVE:
  - busy=1.
  - If hold!=0: hold<=hold-1.
  - If hold==0: sample x,y.
    - On a mismatch (x!=x_exp or y!=y_exp): fail_vec[idx]<=1; err_count<=err_count+1, saturating at 2^ERR_W-1.
    - If idx!=7: idx<=idx+1, {a,b,c}<=idx+1, hold<=HOLD_CYCLES-1.
    - If idx==7: go to DONE; {a,b,c} holds 111.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - pass=1 if err_count==0 (including the final-vector update), else pass=0. Implement this as a registered flag cleared on the first mismatch.
  - Then go to IDLE.
- Timing: each vector is driven for exactly HOLD_CYCLES cycles. done rises 8*HOLD_CYCLES+1 cycles after the start edge (33 with defaults).
- start while busy or during DONE is ignored, with no restart and no effect on results. start held high re-arms from IDLE on the cycle after DONE.
- pass, err_count and fail_vec are stable from DONE until the next accepted start.
- The x/y inputs are assumed synchronous to clk (a combinational path from a/b/c); no synchronizers.

Test Plan:
- Correct DUT, HOLD_CYCLES=4, pulse start -> a,b,c step 000..111 every 4 cycles; done pulses 33 cycles after start; pass=1, err_count=0, fail_vec=8'h00.
- y stuck-at-0 -> vectors 6 and 7 fail; err_count=2, fail_vec=8'hC0, pass=0.
- x inverted, ERR_W=3 -> all vectors fail; fail_vec=8'hFF, err_count saturates at 7, pass=0.
- start re-pulsed at cycle 10 of a run -> ignored; sequence and done timing are unchanged; results match a clean run.
- rst_n low at cycle 15 mid-run -> a/b/c/busy/err_count/fail_vec go to 0 immediately and no done pulse occurs; a new start after release gives a full clean run.
- HOLD_CYCLES=1, start held high continuously -> vectors change every cycle; done at cycle 9; a new run begins from IDLE and done recurs every 10 cycles.
